// File: rtl/hamming_pkg.sv
// Shared Hamming code helpers: code geometry, data-position map and collector FSM states.
// Used by the serial decoder and by the combinational syndrome/correction block.
package hamming_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } coll_state_t;

    function automatic int n_of(input int r);
        return (1 << r) - 1;
    endfunction

    function automatic int k_of(input int r);
        return n_of(r) - r;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // 1-based codeword position of data bit j; data fills the non-power-of-two slots in ascending order
    function automatic int data_pos(input int r, input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= n_of(r); p++) begin
            if (!is_pow2(p)) begin
                if (cnt == j) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and single-bit correction over an N = 2^R-1 bit codeword.
// Bit i of the codeword is position i+1; correction is gated by i_corr_en.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int R = 3,
    localparam int N = n_of(R)
) (
    input  logic [N-1:0] i_cw,
    input  logic         i_corr_en,
    output logic [R-1:0] o_syndrome,
    output logic [N-1:0] o_cw_corr,
    output logic         o_flipped
);

    logic [R-1:0] w_syn;

    // syndrome is the XOR of the indices of every set position
    always_comb begin
        w_syn = '0;
        for (int i = 0; i < N; i++) begin
            if (i_cw[i]) w_syn = w_syn ^ R'(i + 1);
        end
    end

    // N = 2^R-1, so every non-zero syndrome names a real position
    always_comb begin
        o_cw_corr = i_cw;
        for (int i = 0; i < N; i++) begin
            if (i_corr_en && (w_syn == R'(i + 1))) o_cw_corr[i] = ~i_cw[i];
        end
    end

    assign o_syndrome = w_syn;
    assign o_flipped  = i_corr_en && (w_syn != '0);

endmodule

// File: rtl/hamming_serial_decoder.sv
// Serial LSB-first Hamming decoder with single-error correction and a one-entry valid/ready buffer.
// Define HAMMING_SECDED_EN to append an overall even-parity bit and flag double errors.
//
// state | meaning
// IDLE  | waiting for bit_valid & frame_start (position 1)
// SHIFT | collecting positions 2..last; frame_start restarts at position 1
module hamming_serial_decoder
    import hamming_pkg::*;
#(
    parameter  int R     = 3,
    parameter  int CNT_W = 8,
    localparam int N     = n_of(R),
    localparam int K     = k_of(R)
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [K-1:0]     data_out,
    output logic [N-1:0]     cw_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_corrected,
    output logic             err_uncorrectable,
    output logic [R-1:0]     syndrome,
    output logic             overflow,
    output logic [CNT_W-1:0] corr_count
);

`ifdef HAMMING_SECDED_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif
    localparam int BW = $clog2(FL + 1);

    coll_state_t   r_state;
    coll_state_t   w_state_nxt;
    logic [BW-1:0] r_bit_cnt;
    logic [FL-1:0] r_shift;
    logic [FL-1:0] r_chk;
    logic          r_frame_done;

    logic w_start;
    logic w_take;
    logic w_last;

    assign w_start = bit_valid && frame_start;
    assign w_take  = (r_state == SHIFT) && bit_valid && !frame_start;
    assign w_last  = w_take && (r_bit_cnt == BW'(FL - 1));

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start)     w_state_nxt = SHIFT;
        else if (w_last) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_chk        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_start) begin
                r_shift   <= FL'(serial_in);
                r_bit_cnt <= BW'(1);
            end else if (w_take) begin
                for (int i = 1; i < FL; i++) begin
                    if (r_bit_cnt == BW'(i)) r_shift[i] <= serial_in;
                end
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
            end
            // the last bit goes straight into the check register so a new frame can follow at once
            if (w_last) r_chk <= {serial_in, r_shift[FL-2:0]};
        end
    end

    logic [N-1:0] w_cw_corr;
    logic [R-1:0] w_syn;
    logic         w_flipped;
    logic         w_corr_en;
    logic         w_err_corr;
    logic         w_err_unc;

`ifdef HAMMING_SECDED_EN
    logic w_par_mis;
    assign w_par_mis  = ^r_chk;
    assign w_corr_en  = w_par_mis;
    // mismatch with zero syndrome means the parity bit itself flipped
    assign w_err_corr = w_flipped || (w_par_mis && (w_syn == '0));
    assign w_err_unc  = !w_par_mis && (w_syn != '0);
`else
    assign w_corr_en  = 1'b1;
    assign w_err_corr = w_flipped;
    assign w_err_unc  = 1'b0;
`endif

    hamming_syndrome #(.R(R)) u_syndrome (
        .i_cw       (r_chk[N-1:0]),
        .i_corr_en  (w_corr_en),
        .o_syndrome (w_syn),
        .o_cw_corr  (w_cw_corr),
        .o_flipped  (w_flipped)
    );

    logic [K-1:0] w_data;

    for (genvar j = 0; j < K; j++) begin : g_data
        localparam int P = data_pos(R, j) - 1;
        assign w_data[j] = w_cw_corr[P];
    end

    logic         r_res_vld;
    logic [K-1:0] r_res_data;
    logic [N-1:0] r_res_cw;
    logic [R-1:0] r_res_syn;
    logic         r_res_corr;
    logic         r_res_unc;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_res_vld  <= 1'b0;
            r_res_data <= '0;
            r_res_cw   <= '0;
            r_res_syn  <= '0;
            r_res_corr <= 1'b0;
            r_res_unc  <= 1'b0;
        end else begin
            r_res_vld <= r_frame_done;
            if (r_frame_done) begin
                r_res_data <= w_data;
                r_res_cw   <= w_cw_corr;
                r_res_syn  <= w_syn;
                r_res_corr <= w_err_corr;
                r_res_unc  <= w_err_unc;
            end
        end
    end

    logic             r_out_valid;
    logic [K-1:0]     r_out_data;
    logic [N-1:0]     r_out_cw;
    logic [R-1:0]     r_out_syn;
    logic             r_out_corr;
    logic             r_out_unc;
    logic             r_overflow;
    logic [CNT_W-1:0] r_corr_count;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_cw     <= '0;
            r_out_syn    <= '0;
            r_out_corr   <= 1'b0;
            r_out_unc    <= 1'b0;
            r_overflow   <= 1'b0;
            r_corr_count <= '0;
        end else if (r_res_vld && (!r_out_valid || out_ready)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_res_data;
            r_out_cw    <= r_res_cw;
            r_out_syn   <= r_res_syn;
            r_out_corr  <= r_res_corr;
            r_out_unc   <= r_res_unc;
            if (r_res_corr && (r_corr_count != '1)) r_corr_count <= r_corr_count + 1'b1;
        end else begin
            // full and not draining: the incoming result is lost
            if (r_res_vld) r_overflow  <= 1'b1;
            if (out_ready) r_out_valid <= 1'b0;
        end
    end

    assign data_out          = r_out_data;
    assign cw_out            = r_out_cw;
    assign out_valid         = r_out_valid;
    assign err_corrected     = r_out_corr;
    assign err_uncorrectable = r_out_unc;
    assign syndrome          = r_out_syn;
    assign overflow          = r_overflow;
    assign corr_count        = r_corr_count;

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Directed bench for hamming_serial_decoder: an R=3 instance and an R=4 instance with a 2-bit counter.
// Expected results come from an independent parity-check model and are queued per frame.
module tb_hamming_serial_decoder;

`ifdef HAMMING_SECDED_EN
    localparam int SEC = 1;
`else
    localparam int SEC = 0;
`endif

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    logic        a_sin = 0, a_bv = 0, a_fs = 0, a_rdy = 1;
    logic [3:0]  a_data;
    logic [6:0]  a_cw;
    logic        a_ov, a_ec, a_eu, a_ovf;
    logic [2:0]  a_syn;
    logic [7:0]  a_cnt;

    logic        b_sin = 0, b_bv = 0, b_fs = 0, b_rdy = 1;
    logic [10:0] b_data;
    logic [14:0] b_cw;
    logic        b_ov, b_ec, b_eu, b_ovf;
    logic [3:0]  b_syn;
    logic [1:0]  b_cnt;

    hamming_serial_decoder #(.R(3), .CNT_W(8)) u_dut3 (
        .clk1(clk1), .rst(rst), .serial_in(a_sin), .bit_valid(a_bv), .frame_start(a_fs),
        .data_out(a_data), .cw_out(a_cw), .out_valid(a_ov), .out_ready(a_rdy),
        .err_corrected(a_ec), .err_uncorrectable(a_eu), .syndrome(a_syn),
        .overflow(a_ovf), .corr_count(a_cnt)
    );

    hamming_serial_decoder #(.R(4), .CNT_W(2)) u_dut4 (
        .clk1(clk1), .rst(rst), .serial_in(b_sin), .bit_valid(b_bv), .frame_start(b_fs),
        .data_out(b_data), .cw_out(b_cw), .out_valid(b_ov), .out_ready(b_rdy),
        .err_corrected(b_ec), .err_uncorrectable(b_eu), .syndrome(b_syn),
        .overflow(b_ovf), .corr_count(b_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] cw;
        logic [4:0]  syn;
        logic        ec;
        logic        eu;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt3 = 0;
    int   exp_cnt4 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input int r, input logic [31:0] d);
        logic [31:0] c;
        logic        x;
        int          n;
        int          k;
        c = '0;
        n = (1 << r) - 1;
        k = 0;
        for (int p = 1; p <= n; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[k];
                k++;
            end
        end
        for (int b = 0; b < r; b++) begin
            x = 1'b0;
            for (int p = 1; p <= n; p++)
                if ((((p >> b) & 1) == 1) && (p != (1 << b))) x = x ^ c[p-1];
            c[(1 << b) - 1] = x;
        end
        return c;
    endfunction

    function automatic exp_t model(input int r, input logic [31:0] cw, input logic pb);
        exp_t        e;
        logic [4:0]  s;
        logic [31:0] f;
        logic        fix_en;
        int          n;
        int          k;
        n = (1 << r) - 1;
        s = '0;
        for (int b = 0; b < r; b++)
            for (int p = 1; p <= n; p++)
                if (((p >> b) & 1) == 1) s[b] = s[b] ^ cw[p-1];
        f = cw;
`ifdef HAMMING_SECDED_EN
        fix_en = (^cw) ^ pb;
        e.ec   = fix_en;
        e.eu   = !fix_en && (s != 0);
`else
        fix_en = 1'b1 | pb;
        e.ec   = (s != 0);
        e.eu   = 1'b0;
`endif
        if (fix_en && (s != 0)) f[int'(s) - 1] = ~f[int'(s) - 1];
        e.data = '0;
        k = 0;
        for (int p = 1; p <= n; p++) begin
            if ((p & (p - 1)) != 0) begin
                e.data[k] = f[p-1];
                k++;
            end
        end
        e.cw  = f;
        e.syn = s;
        return e;
    endfunction

    task automatic drive(input int r, input logic sin, input logic bv, input logic fs);
        if (r == 3) begin a_sin = sin; a_bv = bv; a_fs = fs; end
        else        begin b_sin = sin; b_bv = bv; b_fs = fs; end
    endtask

    task automatic idle(input int r);
        @(negedge clk1);
        drive(r, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input int r, input logic [31:0] cw, input logic pb, input bit gaps);
        int n;
        int fl;
        n  = (1 << r) - 1;
        fl = n + SEC;
        for (int i = 0; i < fl; i++) begin
            if (gaps && (i % 3 == 2)) begin
                @(negedge clk1);
                drive(r, 1'b1, 1'b0, 1'b0);
            end
            @(negedge clk1);
            drive(r, (i < n) ? cw[i] : pb, 1'b1, i == 0);
        end
    endtask

    task automatic expect_result(input int r, input string tag);
        exp_t e;
        int   t;
        logic ov;
        t  = 0;
        ov = (r == 3) ? a_ov : b_ov;
        while (!ov && t < 40) begin
            @(negedge clk1);
            t++;
            ov = (r == 3) ? a_ov : b_ov;
        end
        chk({tag, "_valid"}, 32'(ov), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (r == 3) begin
                if (e.ec) exp_cnt3 = (exp_cnt3 == 255) ? 255 : exp_cnt3 + 1;
                chk({tag, "_data"}, 32'(a_data), e.data);
                chk({tag, "_cw"},   32'(a_cw),   e.cw);
                chk({tag, "_syn"},  32'(a_syn),  32'(e.syn));
                chk({tag, "_ec"},   32'(a_ec),   32'(e.ec));
                chk({tag, "_eu"},   32'(a_eu),   32'(e.eu));
                chk({tag, "_cnt"},  32'(a_cnt),  32'(exp_cnt3));
            end else begin
                if (e.ec) exp_cnt4 = (exp_cnt4 == 3) ? 3 : exp_cnt4 + 1;
                chk({tag, "_data"}, 32'(b_data), e.data);
                chk({tag, "_cw"},   32'(b_cw),   e.cw);
                chk({tag, "_syn"},  32'(b_syn),  32'(e.syn));
                chk({tag, "_ec"},   32'(b_ec),   32'(e.ec));
                chk({tag, "_eu"},   32'(b_eu),   32'(e.eu));
                chk({tag, "_cnt"},  32'(b_cnt),  32'(exp_cnt4));
            end
        end
    endtask

    task automatic send_chk(input int r, input logic [31:0] cw, input logic pb, input bit gaps,
                            input string tag);
        send(r, cw, pb, gaps);
        sb.push_back(model(r, cw, pb));
        idle(r);
        expect_result(r, tag);
    endtask

    initial begin
        logic [31:0] cw;
        logic [31:0] cwb;
        logic        seen;

        repeat (3) @(negedge clk1);
        chk("rst_valid3", 32'(a_ov), 32'd0);
        chk("rst_data3",  32'(a_data), 32'd0);
        chk("rst_cw3",    32'(a_cw), 32'd0);
        chk("rst_syn3",   32'(a_syn), 32'd0);
        chk("rst_flags3", {29'd0, a_ec, a_eu, a_ovf}, 32'd0);
        chk("rst_cnt3",   32'(a_cnt), 32'd0);
        chk("rst_valid4", 32'(b_ov), 32'd0);
        rst = 1'b0;
        @(negedge clk1);

        // clean R=3 frame with latency check
        cw = encode(3, 32'b1011);
        chk("enc_1010101", cw, 32'b1010101);
        send(3, cw, ^cw, 1'b0);
        sb.push_back(model(3, cw, ^cw));
        idle(3);
        @(negedge clk1);
        chk("lat_edge1", 32'(a_ov), 32'd0);
        @(negedge clk1);
        chk("lat_edge2", 32'(a_ov), 32'd1);
        expect_result(3, "clean3");
        chk("clean3_lit", 32'(a_data), 32'b1011);

        // position 5 flipped
        cw = encode(3, 32'b1011);
        send_chk(3, cw ^ 32'h10, ^cw, 1'b0, "pos5");
        chk("pos5_syn_lit", 32'(a_syn), 32'd5);
        chk("pos5_cnt_lit", 32'(a_cnt), 32'd1);

        // overflow: two back-to-back frames with the consumer stalled
        @(negedge clk1);
        a_rdy = 1'b0;
        cw  = encode(3, 32'b1011);
        cwb = encode(3, 32'b0100);
        send(3, cw, ^cw, 1'b0);
        sb.push_back(model(3, cw, ^cw));
        send(3, cwb, ^cwb, 1'b0);
        idle(3);
        repeat (6) @(negedge clk1);
        chk("ovf_flag", 32'(a_ovf), 32'd1);
        expect_result(3, "ovf_hold");
        @(negedge clk1);
        chk("ovf_stable", 32'(a_data), 32'b1011);
        a_rdy = 1'b1;
        @(negedge clk1);
        chk("ovf_drain", 32'(a_ov), 32'd0);
        chk("ovf_sticky", 32'(a_ovf), 32'd1);

        // abort after 4 bits, then a full frame
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1);
            drive(3, 1'b1, 1'b1, i == 0);
        end
        cw = encode(3, 32'b0110);
        send(3, cw, ^cw, 1'b0);
        sb.push_back(model(3, cw, ^cw));
        idle(3);
        expect_result(3, "abort");
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk1);
            seen = seen | a_ov;
        end
        chk("abort_single", 32'(seen), 32'd0);
        send_chk(3, cw, ^cw, 1'b1, "gaps");

        // R=4: all-zero data clean, then position 15 flipped
        cw = encode(4, 32'd0);
        send_chk(4, cw, 1'b0, 1'b0, "r4_clean");
        send_chk(4, cw ^ 32'h4000, 1'b0, 1'b0, "r4_pos15");
        chk("r4_pos15_lit", 32'(b_syn), 32'd15);

        // reset in the middle of an R=4 frame
        cw = encode(4, 32'h5A3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk1);
            drive(4, cw[i], 1'b1, i == 0);
        end
        @(negedge clk1);
        rst = 1'b1;
        drive(4, 1'b0, 1'b0, 1'b0);
        @(negedge clk1);
        chk("mid_rst_valid", 32'(b_ov), 32'd0);
        chk("mid_rst_data",  32'(b_data), 32'd0);
        chk("mid_rst_cw",    32'(b_cw), 32'd0);
        chk("mid_rst_syn",   32'(b_syn), 32'd0);
        chk("mid_rst_flags", {29'd0, b_ec, b_eu, b_ovf}, 32'd0);
        chk("mid_rst_cnt",   32'(b_cnt), 32'd0);
        chk("mid_rst_ovf3",  32'(a_ovf), 32'd0);
        rst = 1'b0;
        exp_cnt3 = 0;
        exp_cnt4 = 0;
        @(negedge clk1);
        send_chk(4, cw, ^cw, 1'b0, "r4_post_rst");

        // corrected-error counter saturation on the 2-bit instance
        cw = encode(4, 32'h2C5);
        send_chk(4, cw ^ 32'h0001, ^cw, 1'b0, "sat1");
        cw = encode(4, 32'h7FF);
        send_chk(4, cw ^ 32'h0080, ^cw, 1'b0, "sat2");
        cw = encode(4, 32'h013);
        send_chk(4, cw ^ 32'h0400, ^cw, 1'b0, "sat3");
        cw = encode(4, 32'h6A9);
        send_chk(4, cw ^ 32'h4000, ^cw, 1'b0, "sat4");
        chk("sat_lit", 32'(b_cnt), 32'd3);

`ifdef HAMMING_SECDED_EN
        // double error: positions 1 and 2 flipped, parity bit left at 0
        cw = encode(3, 32'b1011);
        send_chk(3, cw ^ 32'h3, 1'b0, 1'b0, "sec_double");
        chk("sec_double_syn", 32'(a_syn), 32'd3);
        chk("sec_double_eu",  32'(a_eu), 32'd1);
        chk("sec_double_cw",  32'(a_cw), 32'b1010110);
        // only the overall parity bit flipped
        send_chk(3, cw, 1'b1, 1'b0, "sec_pflip");
        chk("sec_pflip_ec",   32'(a_ec), 32'd1);
        chk("sec_pflip_data", 32'(a_data), 32'b1011);
`endif

        repeat (4) @(negedge clk1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_serial_decoder.md
Name: hamming_serial_decoder

Overview:
Parametrised serial Hamming decoder, successor to the fixed (7,4) serial codec. It collects an LSB-first serial codeword of length N = 2^R−1, computes the syndrome and corrects any single-bit error. The corrected data word is presented on a one-entry valid/ready output buffer. It sits between the serial channel and the parallel data consumer, single clock domain.

Parameters:
R, 3, parity bits; legal 3..5; N = 2^R−1 (7/15/31), K = N−R (4/11/26)
CNT_W, 8, width of saturating corrected-error counter

Ports:
clk1  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
serial_in  in  1  codeword bit, sampled when bit_valid=1
bit_valid  in  1  qualifies serial_in
frame_start  in  1  marks bit as codeword position 1; only meaningful with bit_valid
data_out  out  K  corrected data; data bits in ascending non-power-of-two position order, data_out[0]=position 3
cw_out  out  N  corrected codeword, bit i = position i+1
out_valid  out  1  output buffer holds a result
out_ready  in  1  consumer accepts when out_valid & out_ready
err_corrected  out  1  single error corrected in current result
err_uncorrectable  out  1  double error detected (SECDED only)
syndrome  out  R  raw syndrome of current result
overflow  out  1  sticky; a result was dropped
corr_count  out  CNT_W  saturating count of corrected results

Behaviour:
- Reset: all outputs 0; FSM in IDLE; bit counter 0.
- Collector FSM, IDLE/SHIFT:
  - IDLE: bit_valid & frame_start → store the bit at position 1, go to SHIFT, counter=1. bit_valid without frame_start is ignored.
  - SHIFT: bit_valid stores the next position. bit_valid low holds state.
  - frame_start & bit_valid while in SHIFT aborts the partial frame silently and restarts at position 1.
  - After the last bit (position N, or N+1 with SECDED), copy the frame to the check register, pulse frame_done and return to IDLE. A new frame may start the very next cycle; there are no bubbles.
- Check stage:
  - Cycle after frame_done: syndrome = XOR of the indices of all set positions.
  - s≠0 and s≤N: flip position s and set err_corrected.
  - Results are registered into the output buffer.
  - Latency: out_valid rises 2 clk1 edges after the edge that sampled the last bit.
- Output buffer:
  - Held stable while out_valid & !out_ready.
  - Load with a simultaneous drain: the new result is loaded and out_valid stays 1.
  - Load while full and not draining: the new result is dropped, overflow is set (cleared only by rst), and the buffer is unchanged.
- corr_count increments on each loaded result with err_corrected=1 and saturates at all-ones.
- rst mid-frame discards everything immediately.

Optional Feature:
HAMMING_SECDED_EN.
- With the macro:
  - Frame is N+1 bits; the last bit is the overall even-parity bit P over positions 1..N.
  - Overall mismatch & s≠0 → correct position s, err_corrected=1.
  - Overall mismatch & s=0 → P itself was in error; data unchanged, err_corrected=1.
  - No mismatch & s≠0 → err_uncorrectable=1, no correction, not counted.
- Without the macro: frame is N bits and err_uncorrectable is tied to 0.

Decomposition:
- Shared package hamming_pkg:
  - functions n_of(R) and k_of(R);
  - function is_pow2(position);
  - data-position index map generator;
  - FSM state typedef {IDLE, SHIFT}.
- One sub-module, hamming_syndrome: combinational syndrome plus correction over N bits, reusable by a future encoder block.

Test Plan:
- R=3, clean frame 1,0,1,0,1,0,1 (frame_start on first bit), out_ready=1 → data_out=4'b1011, cw_out=7'b1010101, syndrome=0, err_corrected=0, out_valid 2 edges after last bit.
- R=3, position 5 flipped (1,0,1,0,0,0,1) → syndrome=3'd5, data_out=4'b1011, err_corrected=1, corr_count=1.
- R=3, out_ready=0, two back-to-back frames → first result held, overflow=1, second dropped; out_ready=1 → first result consumed, out_valid=0.
- R=3, frame_start reasserted after 4 bits, then a full clean frame → single result matching the second frame only. bit_valid gaps mid-frame → same result.
- HAMMING_SECDED_EN, R=3:
  - 1010101 + P=0 with positions 1 and 2 flipped → syndrome=3, err_uncorrectable=1, data uncorrected.
  - Same frame with only P flipped → err_corrected=1, data_out=4'b1011.
- R=4, clean frame of all-zero data, then position 15 flipped → syndrome=4'd15, err_corrected=1. Assert rst mid-frame → all outputs 0, and the next full frame decodes correctly.
